mul_share_arb: RTL and testbench

//  Shares one sequential 8x8 shift-add multiplier (start/done handshake,
//  16-bit product) between NREQ requesters. Round-robin arbitration, one

---
 rtl/mul_share_arb_if.sv | 29 ++
 rtl/mul_share_arb.sv | 102 ++++++++++
 tb/tb_mul_share_arb.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_share_arb_if.sv
// Bundle between client requesters, the shared-multiplier arbiter and the multiplier.
// The slave side is the arbiter; the master side is whatever surrounds it.
interface mul_share_arb_if #(
    parameter int NREQ = 4,
    parameter int W    = 8
);
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   ack;
    logic [2*W-1:0]    rsp_product;
    logic              rsp_err;
    logic              busy;
    logic              mul_start;
    logic [W-1:0]      mul_a;
    logic [W-1:0]      mul_b;
    logic [2*W-1:0]    mul_product;
    logic              mul_done;

    modport slave (
        input  req, req_a, req_b, mul_product, mul_done,
        output ack, rsp_product, rsp_err, busy, mul_start, mul_a, mul_b
    );

    modport master (
        output req, req_a, req_b, mul_product, mul_done,
        input  ack, rsp_product, rsp_err, busy, mul_start, mul_a, mul_b
    );
endinterface

// File: rtl/mul_share_arb.sv
// Round-robin arbiter sharing one sequential multiplier between NREQ requesters,
// one operation in flight, with a watchdog on the multiplier's done strobe.
module mul_share_arb #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int WDOG = 64
) (
    input logic            clk,
    input logic            rst,
    mul_share_arb_if.slave bus
);
    // state | meaning
    // ----- | -------
    // IDLE  | no op in flight; grant next requester round-robin from ptr
    // ISSUE | one-cycle mul_start pulse, watchdog cleared
    // WAIT  | operands held; wait for mul_done or watchdog expiry
    // RESP  | one-cycle ack to the granted requester, advance ptr
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(WDOG);
    // Abort on the cycle cnt reaches WDOG-2 so the ack lands WDOG cycles after mul_start.
    localparam logic [CW-1:0] CNT_LAST = CW'(WDOG - 2);
    localparam logic [IW-1:0] IDX_LAST = IW'(NREQ - 1);

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] grant;
    logic [CW-1:0] cnt;
    logic          gnt_found;
    logic [IW-1:0] gnt_idx;

    always_comb begin : p_pick
        int j;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        j         = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!gnt_found && bus.req[j]) begin
                gnt_found = 1'b1;
                gnt_idx   = IW'(j);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            ptr             <= '0;
            grant           <= '0;
            cnt             <= '0;
            bus.ack         <= '0;
            bus.rsp_product <= '0;
            bus.rsp_err     <= 1'b0;
            bus.busy        <= 1'b0;
            bus.mul_start   <= 1'b0;
            bus.mul_a       <= '0;
            bus.mul_b       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        grant         <= gnt_idx;
                        bus.mul_a     <= bus.req_a[gnt_idx*W +: W];
                        bus.mul_b     <= bus.req_b[gnt_idx*W +: W];
                        bus.mul_start <= 1'b1;
                        bus.busy      <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.mul_start <= 1'b0;
                    cnt           <= '0;
                    state         <= WAIT;
                end
                WAIT: begin
                    if (bus.mul_done) begin
                        bus.rsp_product <= bus.mul_product;
                        bus.rsp_err     <= 1'b0;
                        bus.ack[grant]  <= 1'b1;
                        state           <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        bus.rsp_product <= '0;
                        bus.rsp_err     <= 1'b1;
                        bus.ack[grant]  <= 1'b1;
                        state           <= RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESP: begin
                    bus.ack  <= '0;
                    ptr      <= (grant == IDX_LAST) ? '0 : grant + IW'(1);
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_share_arb.sv
// Bench for mul_share_arb: directed scenarios plus a randomized run against a
// round-robin reference model, with a stub multiplier of random latency.
module tb_mul_share_arb;
    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int WDOG = 64;

    typedef struct {int idx; logic [15:0] prod;} op_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    int         checks = 0;
    int         failures = 0;
    int         mptr = 0;
    logic       stub_dead = 1'b0;
    logic [2:0] mcnt;
    logic [15:0] mprod;
    logic       stub_done;
    logic [15:0] stub_prod;
    logic [7:0] opa [NREQ];
    logic [7:0] opb [NREQ];

    mul_share_arb_if #(.NREQ(NREQ), .W(W)) bus ();
    mul_share_arb #(.NREQ(NREQ), .W(W), .WDOG(WDOG)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    assign bus.mul_done    = stub_done;
    assign bus.mul_product = stub_prod;

    // Stub multiplier: product of the operands seen at mul_start, after 1..6 cycles.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcnt <= '0; mprod <= '0; stub_done <= 1'b0; stub_prod <= '0;
        end else begin
            stub_done <= 1'b0;
            if (bus.mul_start) begin
                mcnt  <= 3'($urandom_range(1, 6));
                mprod <= 16'(bus.mul_a) * 16'(bus.mul_b);
            end else if (mcnt != 3'd0) begin
                mcnt <= mcnt - 3'd1;
                if (mcnt == 3'd1 && !stub_dead) begin
                    stub_done <= 1'b1;
                    stub_prod <= mprod;
                end
            end
        end
    end

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++)
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    task automatic set_req(input int i, input logic v, input logic [7:0] a, input logic [7:0] b);
        bus.req[i] = v;
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
        opa[i] = a;
        opb[i] = b;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.req = '0; bus.req_a = '0; bus.req_b = '0;
        stub_dead = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        mptr = 0;
    endtask

    task automatic wait_start(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            ok = bus.mul_start;
        end
    endtask

    task automatic wait_ack(input int budget, output logic ok, output int n, output int starts);
        ok = 1'b0; n = 0; starts = 0;
        while (!ok && n < budget) begin
            @(negedge clk);
            n++;
            if (bus.mul_start) starts++;
            ok = (bus.ack != '0);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.ack, bus.rsp_product, bus.rsp_err, bus.mul_start, bus.mul_a, bus.mul_b} !== '0) begin
            failures++;
            $display("FAIL reset_outputs ack=%b prod=%h err=%b start=%b a=%h b=%h want all 0",
                     bus.ack, bus.rsp_product, bus.rsp_err, bus.mul_start, bus.mul_a, bus.mul_b);
        end
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        bus.req = '1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.mul_start !== 1'b0 || bus.ack !== '0) begin
            failures++; $display("FAIL reset_hold start=%b ack=%b want 0", bus.mul_start, bus.ack);
        end
        bus.req = '0;
    endtask

    task automatic test_single();
        logic ok; int n, st;
        apply_reset();
        set_req(0, 1'b1, 8'h81, 8'h13);
        @(negedge clk);
        checks++;
        if (bus.mul_start !== 1'b1 || bus.busy !== 1'b1) begin
            failures++; $display("FAIL single_start_latency start=%b busy=%b want 1,1", bus.mul_start, bus.busy);
        end
        wait_ack(40, ok, n, st);
        checks++;
        if (!ok) begin failures++; $display("FAIL single_ack_timeout got no ack want ack"); end
        checks++;
        if (bus.ack !== 4'b0001 || bus.rsp_product !== 16'h0993 || bus.rsp_err !== 1'b0) begin
            failures++; $display("FAIL single_result ack=%b prod=%h err=%b want 0001 0993 0", bus.ack, bus.rsp_product, bus.rsp_err);
        end
        checks++;
        if (st != 0) begin failures++; $display("FAIL single_start_pulses got=%0d want=1", st + 1); end
        bus.req[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.ack !== '0) begin
            failures++; $display("FAIL single_idle busy=%b ack=%b want 0", bus.busy, bus.ack);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.rsp_product !== 16'h0993 || bus.mul_start !== 1'b0) begin
            failures++; $display("FAIL single_hold prod=%h start=%b want 0993 0", bus.rsp_product, bus.mul_start);
        end
    endtask

    task automatic test_all4();
        logic ok; int n, st, e;
        logic [NREQ-1:0] pend;
        apply_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 8'(i + 1), 8'd3);
        pend = '1;
        for (int k = 0; k < NREQ; k++) begin
            e = rr_pick(pend, mptr);
            wait_ack(40, ok, n, st);
            checks++;
            if (!ok || e != k || bus.ack !== (4'b0001 << k) || $countones(bus.ack) != 1
                || bus.rsp_product !== 16'((k + 1) * 3) || bus.rsp_err !== 1'b0) begin
                failures++;
                $display("FAIL all4_order k=%0d ack=%b prod=%0d err=%b want ack=%b prod=%0d err=0",
                         k, bus.ack, bus.rsp_product, bus.rsp_err, 4'b0001 << k, (k + 1) * 3);
            end
            bus.req[k] = 1'b0;
            pend[k] = 1'b0;
            mptr = (k + 1) % NREQ;
        end
        @(negedge clk);
        bus.req = '1;
        wait_ack(40, ok, n, st);
        bus.req = '0;
        checks++;
        if (!ok || bus.ack !== 4'b0001) begin
            failures++; $display("FAIL all4_ptr_wrap ack=%b want 0001", bus.ack);
        end
    endtask

    task automatic test_rr();
        logic ok; int n, st;
        int order [3] = '{2, 1, 2};
        apply_reset();
        set_req(2, 1'b1, 8'($urandom), 8'($urandom));
        wait_start(10, ok);
        set_req(1, 1'b1, 8'($urandom), 8'($urandom));
        for (int k = 0; k < 3; k++) begin
            wait_ack(40, ok, n, st);
            checks++;
            if (!ok || bus.ack !== (4'b0001 << order[k])
                || bus.rsp_product !== 16'(opa[order[k]]) * 16'(opb[order[k]])) begin
                failures++;
                $display("FAIL rr_order k=%0d ack=%b prod=%h want ack=%b prod=%h", k, bus.ack,
                         bus.rsp_product, 4'b0001 << order[k], 16'(opa[order[k]]) * 16'(opb[order[k]]));
            end
            if (k == 0) set_req(2, 1'b1, 8'($urandom), 8'($urandom));
            if (k == 1) bus.req[1] = 1'b0;
            if (k == 2) bus.req[2] = 1'b0;
        end
    endtask

    task automatic test_watchdog();
        logic ok; int n, st;
        logic [7:0] a, b;
        apply_reset();
        stub_dead = 1'b1;
        set_req(3, 1'b1, 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)));
        wait_start(10, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL wdog_start_timeout got no mul_start want pulse"); end
        wait_ack(200, ok, n, st);
        checks++;
        if (!ok || n != WDOG) begin failures++; $display("FAIL wdog_latency got=%0d want=%0d", n, WDOG); end
        checks++;
        if (bus.ack !== 4'b1000 || bus.rsp_err !== 1'b1 || bus.rsp_product !== 16'h0) begin
            failures++; $display("FAIL wdog_result ack=%b err=%b prod=%h want 1000 1 0000", bus.ack, bus.rsp_err, bus.rsp_product);
        end
        bus.req[3] = 1'b0;
        stub_dead = 1'b0;
        @(negedge clk);
        a = 8'($urandom); b = 8'($urandom);
        set_req(0, 1'b1, a, b);
        wait_ack(40, ok, n, st);
        bus.req[0] = 1'b0;
        checks++;
        if (!ok || bus.ack !== 4'b0001 || bus.rsp_err !== 1'b0 || bus.rsp_product !== 16'(a) * 16'(b)) begin
            failures++; $display("FAIL wdog_recover ack=%b err=%b prod=%h want 0001 0 %h", bus.ack, bus.rsp_err, bus.rsp_product, 16'(a) * 16'(b));
        end
    endtask

    task automatic test_reset_mid();
        logic ok; int n, st;
        apply_reset();
        set_req(1, 1'b1, 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)));
        wait_start(10, ok);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.ack, bus.rsp_product, bus.rsp_err, bus.busy, bus.mul_start, bus.mul_a, bus.mul_b} !== '0) begin
            failures++;
            $display("FAIL rstmid_outputs ack=%b prod=%h err=%b busy=%b start=%b a=%h b=%h want all 0",
                     bus.ack, bus.rsp_product, bus.rsp_err, bus.busy, bus.mul_start, bus.mul_a, bus.mul_b);
        end
        bus.req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        mptr = 0;
        set_req(2, 1'b1, 8'($urandom), 8'($urandom));
        wait_ack(40, ok, n, st);
        bus.req[2] = 1'b0;
        checks++;
        if (!ok || bus.ack !== 4'b0100 || bus.rsp_product !== 16'(opa[2]) * 16'(opb[2]) || bus.rsp_err !== 1'b0) begin
            failures++; $display("FAIL rstmid_after ack=%b prod=%h want 0100 %h", bus.ack, bus.rsp_product, 16'(opa[2]) * 16'(opb[2]));
        end
    endtask

    task automatic test_latch();
        logic ok; int n, st;
        logic [7:0] a, b;
        apply_reset();
        a = 8'($urandom); b = 8'($urandom);
        set_req(0, 1'b1, a, b);
        wait_start(10, ok);
        set_req(0, 1'b0, a ^ 8'h5A, b ^ 8'hA5);
        @(negedge clk);
        checks++;
        if (bus.mul_a !== a || bus.mul_b !== b) begin
            failures++; $display("FAIL latch_hold a=%h b=%h want %h %h", bus.mul_a, bus.mul_b, a, b);
        end
        wait_ack(40, ok, n, st);
        checks++;
        if (!ok || bus.ack !== 4'b0001 || bus.rsp_product !== 16'(a) * 16'(b)) begin
            failures++; $display("FAIL latch_result ack=%b prod=%h want 0001 %h", bus.ack, bus.rsp_product, 16'(a) * 16'(b));
        end
    endtask

    task automatic test_random();
        op_t q[$];
        op_t op;
        logic [NREQ-1:0] prev_req, acked;
        int g, served;
        apply_reset();
        prev_req = '0;
        served = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acked = '0;
            if (bus.mul_start) begin
                g = rr_pick(prev_req, mptr);
                checks++;
                if (g < 0 || q.size() != 0 || bus.mul_a !== opa[g] || bus.mul_b !== opb[g]) begin
                    failures++;
                    $display("FAIL rand_grant c=%0d a=%h b=%h inflight=%0d want idx=%0d", c, bus.mul_a, bus.mul_b, q.size(), g);
                end
                if (g >= 0) q.push_back('{g, 16'(opa[g]) * 16'(opb[g])});
            end
            if (bus.ack != '0) begin
                checks++;
                if (q.size() == 0) begin
                    failures++; $display("FAIL rand_spurious_ack c=%0d ack=%b want none", c, bus.ack);
                end else begin
                    op = q.pop_front();
                    if (bus.ack !== (4'b0001 << op.idx) || bus.rsp_product !== op.prod || bus.rsp_err !== 1'b0) begin
                        failures++;
                        $display("FAIL rand_ack c=%0d ack=%b prod=%h err=%b want ack=%b prod=%h err=0",
                                 c, bus.ack, bus.rsp_product, bus.rsp_err, 4'b0001 << op.idx, op.prod);
                    end
                    mptr = (op.idx + 1) % NREQ;
                    acked[op.idx] = 1'b1;
                    bus.req[op.idx] = 1'b0;
                    served++;
                end
            end
            if (c < 2800)
                for (int i = 0; i < NREQ; i++)
                    if (!bus.req[i] && !acked[i] && $urandom_range(0, 3) == 0)
                        set_req(i, 1'b1, 8'($urandom), 8'($urandom));
            prev_req = bus.req;
        end
        checks++;
        if (q.size() != 0 || bus.req !== '0 || served < 50) begin
            failures++; $display("FAIL rand_drain inflight=%0d req=%b served=%0d want 0 0000 >=50", q.size(), bus.req, served);
        end
    endtask

    initial begin
        bus.req = '0; bus.req_a = '0; bus.req_b = '0;
        test_reset();
        test_single();
        test_all4();
        test_rr();
        test_watchdog();
        test_reset_mid();
        test_latch();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout simulation did not complete");
        $fatal(1);
    end
endmodule
